ysyx_22040750_load_unit: RTL
============================

Name: ysyx_22040750_load_unit

Overview:
- Load-side counterpart of the store-data replicator in the MEM stage.
- Accepts one load request at a time and waits for the 64-bit memory read beat.
- Extracts the addressed byte, half, word or dword, then zero- or sign-extends it.
- Holds the result for writeback under a valid/ready handshake; flags misaligned accesses instead of issuing them.

Parameters:
- RD_W, 5, width of the destination-register tag carried with the request.
- XLEN, 64, data width. Only 64 is supported.

Ports:
- I_sys_clk  in  1  clock; all state updates on the rising edge.
- I_rst  in  1  reset; synchronous, active-high.
- I_req_valid  in  1  load request present.
- O_req_ready  out  1  block can accept a request; high only in IDLE.
- I_req_addr  in  3  byte offset within the 8-byte beat (addr[2:0]).
- I_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- I_req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- I_req_rd  in  RD_W  destination register tag.
- I_mem_rvalid  in  1  memory read data valid; one-cycle pulse.
- I_mem_rdata  in  64  raw aligned 64-bit memory beat.
- O_wb_valid  out  1  result valid to WB.
- I_wb_ready  in  1  WB accepts the result.
- O_wb_data  out  64  extended load result.
- O_wb_rd  out  RD_W  tag of the result.
- O_misalign  out  1  result corresponds to a misaligned request; qualified by O_wb_valid.

Behaviour:
- FSM states: IDLE, WAIT, OUT.
- Reset (synchronous, any state): state becomes IDLE. All outputs and registers go to 0 except O_req_ready, which is 1. Any in-flight request is dropped. A later I_mem_rvalid is ignored because the block is in IDLE.
- IDLE:
  - O_req_ready = 1. A request is accepted on I_req_valid & O_req_ready.
  - On accept, latch addr, size, unsigned and rd.
  - Misaligned request (half with addr[0] != 0, word with addr[1:0] != 0, dword with addr != 0): go to OUT with O_wb_data = 0 and O_misalign = 1. The upstream stage does not issue memory for these, so no rvalid is awaited.
  - Aligned request: go to WAIT.
- WAIT:
  - O_req_ready = 0.
  - On I_mem_rvalid, register the extracted result with O_misalign = 0 and go to OUT.
  - Latency: rvalid in cycle N gives O_wb_valid high in cycle N+1. No combinational path from rdata to O_wb_data.
- OUT:
  - O_wb_valid = 1. O_wb_data, O_wb_rd and O_misalign are held stable until the handshake completes.
  - On I_wb_ready, go to IDLE. The next request can be accepted the following cycle; there is no same-cycle reissue.
  - Back-to-back throughput is therefore one load per 3 cycles minimum.
- Extraction, with sh = addr*8:
  - byte = rdata[sh+7:sh]
  - half = rdata[sh+15:sh]
  - word = rdata[sh+31:sh]
  - dword = rdata
  - Sign extension uses the MSB of the field unless unsigned. Dword ignores unsigned.
- Stray I_mem_rvalid in IDLE or OUT: ignored, no state change.
- I_req_valid in WAIT or OUT: not accepted, since ready is low.

Decomposition:
- Shared package: size encodings (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3) and the FSM state encodings, localparams in the common defines file.
- Sub-module ysyx_22040750_ld_extract: purely combinational. Inputs rdata, addr, size, unsigned. Outputs the extended 64-bit value and a misalign flag. The top-level misalign check reuses this module's flag.

Test Plan:
- lb, addr=7, rdata=0xF0E1D2C3B4A59687: rvalid at cycle N -> cycle N+1 O_wb_valid=1, O_wb_data=0xFFFFFFFFFFFFFFF0.
- lbu addr=1 -> 0x96. lh addr=6 -> 0xFFFFFFFFFFFFF0E1. lwu addr=4 -> 0x00000000F0E1D2C3. lw addr=0 -> 0xFFFFFFFFB4A59687. ld -> 0xF0E1D2C3B4A59687.
- Misaligned lw, addr=2, rd=9: accepted in IDLE -> next cycle O_wb_valid=1, O_misalign=1, O_wb_data=0, O_wb_rd=9. No rvalid is needed.
- Backpressure: I_wb_ready held low 3 cycles in OUT -> outputs stable, O_req_ready=0, extra rvalid pulses ignored. Ready high -> IDLE next cycle.
- Reset in WAIT: I_rst pulsed one cycle -> IDLE, O_wb_valid=0, O_req_ready=1. A subsequent rvalid produces no output.
- Stray rvalid in IDLE with rdata=0x1234 -> O_wb_valid stays 0 and state stays IDLE.

Source files
------------

// File: rtl/ysyx_22040750_load_unit_pkg.sv
// Shared encodings for the MEM-stage load unit: access sizes and FSM states.
package ysyx_22040750_load_unit_pkg;

    // Access size encodings carried on the request.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Load unit FSM: wait for a request, wait for the memory beat, hold the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/ysyx_22040750_ld_extract.sv
// Combinational field extraction and zero/sign extension from a 64-bit beat,
// plus the natural-alignment check for the access size.
module ysyx_22040750_ld_extract
    import ysyx_22040750_load_unit_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] ext_data,
    output logic        misalign
);

    // Low 32 bits of the beat after moving the addressed byte down to bit 0.
    logic [31:0] win;

    // Select the field by size and extend it to 64 bits.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        win      = 32'(rdata >> {addr, 3'b000});
        ext_data = rdata;
        misalign = 1'b0;
        case (size)
            SZ_B: begin
                ext_data = is_unsigned ? {56'd0, win[7:0]} : {{56{win[7]}}, win[7:0]};
            end
            SZ_H: begin
                ext_data = is_unsigned ? {48'd0, win[15:0]} : {{48{win[15]}}, win[15:0]};
                misalign = addr[0];
            end
            SZ_W: begin
                ext_data = is_unsigned ? {32'd0, win} : {{32{win[31]}}, win};
                misalign = (addr[1:0] != 2'd0);
            end
            SZ_D: begin
                // Dword fills the register; signedness is irrelevant.
                ext_data = rdata;
                misalign = (addr != 3'd0);
            end
        endcase
    end

endmodule

// File: rtl/ysyx_22040750_load_unit.sv
// MEM-stage load unit: accepts one load at a time, waits for the memory beat,
// extracts/extends the addressed field and holds it for writeback under
// valid/ready. Misaligned requests bypass memory and return a flagged zero.
module ysyx_22040750_load_unit
    import ysyx_22040750_load_unit_pkg::*;
#(
    parameter int RD_W = 5,
    parameter int XLEN = 64
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic            I_req_valid,
    output logic            O_req_ready,
    input  logic [2:0]      I_req_addr,
    input  logic [1:0]      I_req_size,
    input  logic            I_req_unsigned,
    input  logic [RD_W-1:0] I_req_rd,
    input  logic            I_mem_rvalid,
    input  logic [XLEN-1:0] I_mem_rdata,
    output logic            O_wb_valid,
    input  logic            I_wb_ready,
    output logic [XLEN-1:0] O_wb_data,
    output logic [RD_W-1:0] O_wb_rd,
    output logic            O_misalign
);

    state_t            state_q, state_d;
    logic [2:0]        addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic              req_ready_q, req_ready_d;
    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic              misalign_q, misalign_d;

    logic              in_idle;
    logic [2:0]        ex_addr;
    logic [1:0]        ex_size;
    logic              ex_unsigned;
    logic [63:0]       ex_data;
    logic              ex_misalign;

    // In IDLE the extractor looks at the live request so its misalign flag
    // screens the request at accept time; afterwards it uses the latched copy.
    assign in_idle     = (state_q == ST_IDLE);
    assign ex_addr     = in_idle ? I_req_addr     : addr_q;
    assign ex_size     = in_idle ? I_req_size     : size_q;
    assign ex_unsigned = in_idle ? I_req_unsigned : unsigned_q;

    ysyx_22040750_ld_extract u_extract (
        .rdata       (I_mem_rdata),
        .addr        (ex_addr),
        .size        (ex_size),
        .is_unsigned (ex_unsigned),
        .ext_data    (ex_data),
        .misalign    (ex_misalign)
    );

    // Next-state and next-output logic; everything holds unless a transition fires.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        req_ready_d = req_ready_q;
        wb_valid_d  = wb_valid_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        misalign_d  = misalign_q;
        case (state_q)
            ST_IDLE: begin
                if (I_req_valid && req_ready_q) begin
                    addr_d      = I_req_addr;
                    size_d      = I_req_size;
                    unsigned_d  = I_req_unsigned;
                    wb_rd_d     = I_req_rd;
                    req_ready_d = 1'b0;
                    if (ex_misalign) begin
                        // No memory access is issued, so report immediately.
                        state_d    = ST_OUT;
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (I_mem_rvalid) begin
                    state_d    = ST_OUT;
                    wb_valid_d = 1'b1;
                    wb_data_d  = ex_data;
                    misalign_d = 1'b0;
                end
            end
            ST_OUT: begin
                if (I_wb_ready) begin
                    state_d     = ST_IDLE;
                    wb_valid_d  = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                wb_valid_d  = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; synchronous reset drops any in-flight load.
    always_ff @(posedge I_sys_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (I_rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            req_ready_q <= 1'b1;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            req_ready_q <= req_ready_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            misalign_q  <= misalign_d;
        end
    end

    assign O_req_ready = req_ready_q;
    assign O_wb_valid  = wb_valid_q;
    assign O_wb_data   = wb_data_q;
    assign O_wb_rd     = wb_rd_q;
    assign O_misalign  = misalign_q;

endmodule
